pluck_exciter: RTL and testbench

Excitation source that feeds the Karplus-Strong delay line. A pluck event starts a burst: `trig` is driven high for exactly `shift_register_length` sample strobes, and LFSR white noise is driven on `dnoise`. The outputs connect directly to the `trig` and `dnoise` inputs of the configurable delay line. The block handles burst length, amplitude scaling, retrigger and completion signalling.

---
 rtl/ks_pkg.sv | 19 +
 rtl/lfsr32_galois.sv | 35 +++
 rtl/pluck_exciter.sv | 125 ++++++++++++
 tb/tb_pluck_exciter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared definitions for the Karplus-Strong excitation path.
package ks_pkg;

    localparam int          DATA_W    = 32;
    localparam int          LEN_W     = 10;
    localparam logic [31:0] LFSR_SEED = 32'h1234_5678;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // One right-shifting Galois step: the bit shifted out selects the feedback mask.
    function automatic logic [31:0] galois_step(input logic [31:0] x, input logic [31:0] poly);
        galois_step = {1'b0, x[31:1]} ^ (x[0] ? poly : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR noise source; advances only when en is high.
module lfsr32_galois #(
    parameter logic [31:0] POLY = ks_pkg::LFSR_POLY,
    parameter logic [31:0] SEED = ks_pkg::LFSR_SEED
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    output logic [31:0] q
);
    import ks_pkg::*;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // Next value: hold unless enabled.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = galois_step(lfsr_q, POLY);
        end
    end

    // State register; reset (active-high) reloads the non-zero seed.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/pluck_exciter.sv
// Pluck burst generator: drives trig and scaled LFSR noise into the delay line.
module pluck_exciter #(
    parameter int          DATA_W    = ks_pkg::DATA_W,
    parameter int          LEN_W     = ks_pkg::LEN_W,
    parameter logic [31:0] LFSR_SEED = ks_pkg::LFSR_SEED,
    parameter logic [31:0] LFSR_POLY = ks_pkg::LFSR_POLY
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sample_en,
    input  logic                     pluck,
    input  logic [LEN_W-1:0]         shift_register_length,
    input  logic [3:0]               velocity,
    output logic                     trig,
    output logic signed [DATA_W-1:0] dnoise,
    output logic                     busy,
    output logic                     done
);
    import ks_pkg::*;

    state_t                   state_q, state_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic [3:0]               vel_q, vel_d;
    logic signed [DATA_W-1:0] dnoise_q, dnoise_d;
    logic                     done_q, done_d;
    logic [31:0]              lfsr_q;
    logic [31:0]              lfsr_next;
    logic                     lfsr_en;

    // Amplitude scaling: arithmetic shift keeps the noise sign.
    function automatic logic signed [DATA_W-1:0] scale(input logic [31:0] x, input logic [3:0] sh);
        logic signed [31:0] s;
        s = $signed(x) >>> sh;
        return DATA_W'(s);
    endfunction

    assign lfsr_en   = (state_q == BURST) && sample_en;
    assign lfsr_next = galois_step(lfsr_q, LFSR_POLY);

    lfsr32_galois #(
        .POLY (LFSR_POLY),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (lfsr_en),
        .q       (lfsr_q)
    );

    // Next-state logic: accept plucks, count strobes, retrigger and finish bursts.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vel_d    = vel_q;
        dnoise_d = dnoise_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pluck) begin
                    if (shift_register_length != '0) begin
                        state_d  = BURST;
                        cnt_d    = shift_register_length;
                        vel_d    = velocity;
                        dnoise_d = scale(lfsr_q, velocity);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            BURST: begin
                if (pluck) begin
                    // Retrigger wins over a coincident final strobe; a zero length aborts.
                    if (shift_register_length != '0) begin
                        cnt_d = shift_register_length;
                        vel_d = velocity;
                        if (sample_en) begin
                            dnoise_d = scale(lfsr_next, velocity);
                        end
                    end else begin
                        state_d  = IDLE;
                        cnt_d    = '0;
                        dnoise_d = '0;
                        done_d   = 1'b1;
                    end
                end else if (sample_en) begin
                    if (cnt_q == LEN_W'(1)) begin
                        state_d  = IDLE;
                        cnt_d    = '0;
                        dnoise_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        cnt_d    = cnt_q - LEN_W'(1);
                        dnoise_d = scale(lfsr_next, vel_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any burst without a done pulse.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            vel_q    <= '0;
            dnoise_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vel_q    <= vel_d;
            dnoise_q <= dnoise_d;
            done_q   <= done_d;
        end
    end

    assign trig   = (state_q == BURST);
    assign busy   = (state_q == BURST);
    assign dnoise = dnoise_q;
    assign done   = done_q;

endmodule

// File: tb/tb_pluck_exciter.sv
// Scoreboard bench for pluck_exciter: stimulus pushes expected bursts, a monitor checks them.
module tb_pluck_exciter;

    logic               clk;
    logic               reset_n;
    logic               sample_en;
    logic               pluck;
    logic [9:0]         shift_register_length;
    logic [3:0]         velocity;
    logic               trig;
    logic signed [31:0] dnoise;
    logic               busy;
    logic               done;

    pluck_exciter dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .sample_en             (sample_en),
        .pluck                 (pluck),
        .shift_register_length (shift_register_length),
        .velocity              (velocity),
        .trig                  (trig),
        .dnoise                (dnoise),
        .busy                  (busy),
        .done                  (done)
    );

    typedef struct packed {
        logic [15:0]      strobes;
        logic [3:0]       rises;
        logic [3:0]       nsamp;
        logic [4:0][31:0] samp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   se_period = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int st, input int ri, input int ns,
                            input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                            input logic [31:0] s3, input logic [31:0] s4);
        exp_t e;
        e.strobes = 16'(st);
        e.rises   = 4'(ri);
        e.nsamp   = 4'(ns);
        e.samp[0] = s0;
        e.samp[1] = s1;
        e.samp[2] = s2;
        e.samp[3] = s3;
        e.samp[4] = s4;
        sb_q.push_back(e);
    endtask

    task automatic do_pluck(input int len, input int vel);
        pluck                 = 1'b1;
        shift_register_length = 10'(len);
        velocity              = 4'(vel);
        tick(1);
        pluck                 = 1'b0;
        shift_register_length = 10'd0;
        velocity              = 4'd0;
    endtask

    task automatic do_reset();
        reset_n = 1'b1;
        tick(1);
        reset_n = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (sb_q.size() == 0) break;
            tick(1);
        end
        chk(name, 32'(sb_q.size()), 32'd0);
        tick(2);
    endtask

    // sample_en pattern generator: a strobe every se_period clocks
    initial begin
        int se_cnt;
        se_cnt    = 0;
        sample_en = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            se_cnt++;
            sample_en = (se_period <= 1) ? 1'b1 : ((se_cnt % se_period) == 0);
        end
    end

    // Monitor: follows each burst on the falling edge and retires it on done.
    initial begin
        int   m_strobes, m_rises, m_k;
        logic p_trig, p_se, p_done;
        logic [31:0] p_dn;
        exp_t e;
        m_strobes = 0; m_rises = 0; m_k = 0;
        p_trig = 1'b0; p_se = 1'b0; p_done = 1'b0; p_dn = '0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                m_strobes = 0; m_rises = 0; m_k = 0;
                p_trig = 1'b0; p_se = 1'b0; p_done = 1'b0; p_dn = '0;
                continue;
            end
            if (trig && (!p_trig || p_se)) begin
                if (sb_q.size() > 0 && m_k < int'(sb_q[0].nsamp))
                    chk($sformatf("dnoise_sample%0d", m_k), dnoise, sb_q[0].samp[m_k]);
                m_k++;
            end else if (trig && p_trig && !p_se) begin
                chk("dnoise_hold", dnoise, p_dn);
            end
            if (!trig) chk("idle_dnoise", dnoise, 32'd0);
            chk("busy_eq_trig", 32'(busy), 32'(trig));
            if (trig && !p_trig) m_rises++;
            if (done) begin
                chk("done_width", 32'(p_done), 32'd0);
                chk("trig_at_done", 32'(trig), 32'd0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("burst_strobes", 32'(m_strobes), 32'(e.strobes));
                    chk("trig_rises", 32'(m_rises), 32'(e.rises));
                end
                m_strobes = 0; m_rises = 0; m_k = 0;
            end
            if (trig && sample_en) m_strobes++;
            p_trig = trig;
            p_se   = trig && sample_en;
            p_done = done;
            p_dn   = dnoise;
        end
    end

    // Directed stimulus
    initial begin
        reset_n               = 1'b1;
        pluck                 = 1'b0;
        shift_register_length = 10'd0;
        velocity              = 4'd0;
        tick(3);
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_dnoise", dnoise, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset_n = 1'b0;
        tick(2);

        // basic burst, full scale
        push_exp(5, 1, 5, 32'h1234_5678, 32'h091A_2B3C, 32'h048D_159E, 32'h0246_8ACF, 32'h8103_4564);
        do_pluck(5, 0);
        wait_drain("t1_timeout", 30);

        // attenuation by 16 with sign extension on the fifth sample
        do_reset();
        push_exp(5, 1, 5, 32'h0123_4567, 32'h0091_A2B3, 32'h0048_D159, 32'h0024_68AC, 32'hF810_3456);
        do_pluck(5, 4);
        wait_drain("t2_timeout", 30);

        // sparse strobes
        do_reset();
        se_period = 4;
        tick(1);
        push_exp(3, 1, 3, 32'h1234_5678, 32'h091A_2B3C, 32'h048D_159E, 32'h0, 32'h0);
        do_pluck(3, 0);
        wait_drain("t3_timeout", 60);
        se_period = 1;
        tick(2);

        // retrigger mid-burst, then retrigger on the final strobe
        push_exp(11, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        do_pluck(8, 0);
        tick(6);
        do_pluck(4, 0);
        wait_drain("t4a_timeout", 40);
        push_exp(12, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        do_pluck(8, 0);
        tick(7);
        do_pluck(4, 0);
        wait_drain("t4b_timeout", 40);

        // zero length, then maximum length
        push_exp(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        do_pluck(0, 0);
        wait_drain("t5a_timeout", 10);
        push_exp(1023, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        do_pluck(1023, 0);
        wait_drain("t5b_timeout", 1100);

        // reset mid-burst aborts and reseeds
        do_reset();
        do_pluck(20, 0);
        tick(5);
        reset_n = 1'b1;
        tick(1);
        chk("abort_trig", 32'(trig), 32'd0);
        chk("abort_dnoise", dnoise, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        reset_n = 1'b0;
        tick(2);
        push_exp(2, 1, 1, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h0);
        do_pluck(2, 0);
        wait_drain("t6_timeout", 20);

        chk("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
